// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button conditioner.
// The state enum is shared with anything that wants to peek at the debouncer's
// FSM (for example a status display). The timing constants assume the
// DE2-115 50 MHz board clock.
package key_debounce_pkg;

  // Debouncer states. The two *_CHK states are "candidate change" states.
  // In them, the new key value must stay stable before it is accepted.
  typedef enum logic [1:0] {
    S_UP     = 2'd0,
    S_DN_CHK = 2'd1,
    S_DOWN   = 2'd2,
    S_UP_CHK = 2'd3
  } key_state_t;

  // Board clock and the two human-scale delays derived from it.
  localparam int CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int LONG_1S       = CLK_HZ;

  // Default synchronizer depth for a single asynchronous button input.
  localparam int SYNC_DEFAULT  = 2;

  // Counter width that can hold values up to (n-1). The width never drops
  // below one bit, so small test parameters still give a legal vector.
  function automatic int cnt_width(input int n);
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_sync_ff.sv
// Reusable asynchronous-reset synchronizer chain.
// An asynchronous input is sampled into the first flop. It then passes through
// STAGES-1 more flops, which lets any metastability resolve before the value
// reaches downstream logic. On reset, every stage is loaded with RST_VAL. This
// lets the consumer start from a known idle value, rather than from whatever
// the pin happened to show when reset was applied.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw input one stage deeper on every clock.
  // Reset fills the whole chain with the idle value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner for an active-low DE2-115 KEY input.
// The raw key passes through a synchronizer chain and is inverted, so 1 means
// "held". A four-state FSM then accepts a change only after the new value has
// been stable for DEBOUNCE_CYCLES consecutive checks. On acceptance it emits a
// one-cycle press or release pulse, and it keeps a debounced level.
// A second counter times how long the debounced level has been high. It fires
// a single long-press pulse after LONG_CYCLES.
// Every output comes straight from a flop, so no combinational path runs from
// the button pin to any consumer.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int LONG_CYCLES     = LONG_1S
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_released,
  output logic o_level,
  output logic o_long_press
);

  // dcnt counts 0 .. DEBOUNCE_CYCLES-1. lcnt counts 0 .. LONG_CYCLES and then
  // saturates.
  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int LW = cnt_width(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DCNT_ZERO = '0;
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [LW-1:0] LCNT_ZERO = '0;
  localparam logic [LW-1:0] LCNT_ONE  = LW'(1);
  localparam logic [LW-1:0] LCNT_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LCNT_PRE  = LW'(LONG_CYCLES - 1);

  // Synchronized key. The chain resets to 1 (the raw "released" level), so
  // w_key_s starts at 0 and a key held through reset still looks like a fresh
  // press afterwards.
  logic       w_key_sync_n;
  logic       w_key_s;

  // Registered state and counters.
  key_state_t r_state;
  logic [DW-1:0] r_dcnt;
  logic [LW-1:0] r_lcnt;
  logic       r_level;
  logic       r_pressed;
  logic       r_released;
  logic       r_long;

  // Next-state values, produced by the single combinational block.
  key_state_t w_state_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [LW-1:0] w_lcnt_nxt;
  logic       w_level_nxt;
  logic       w_pressed_nxt;
  logic       w_released_nxt;
  logic       w_long_nxt;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_key_n),
    .o_q     (w_key_sync_n)
  );

  assign w_key_s = ~w_key_sync_n;

  // Next-state logic: debounce FSM with its stability counter, plus the
  // long-press timer. Pulses default to 0, so each one lasts a single cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_dcnt_nxt     = r_dcnt;
    w_level_nxt    = r_level;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
    w_lcnt_nxt     = r_lcnt;
    w_long_nxt     = 1'b0;

    // dcnt is cleared on every state change, so it restarts from 0 in
    // whichever check state comes next and can never wrap.
    case (r_state)
      S_UP: begin
        if (w_key_s) begin
          w_state_nxt = S_DN_CHK;
          w_dcnt_nxt  = DCNT_ZERO;
        end
      end

      S_DN_CHK: begin
        if (!w_key_s) begin
          // The press candidate bounced back open: drop it silently.
          w_state_nxt = S_UP;
          w_dcnt_nxt  = DCNT_ZERO;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt   = S_DOWN;
          w_dcnt_nxt    = DCNT_ZERO;
          w_level_nxt   = 1'b1;
          w_pressed_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_ONE;
        end
      end

      S_DOWN: begin
        if (!w_key_s) begin
          w_state_nxt = S_UP_CHK;
          w_dcnt_nxt  = DCNT_ZERO;
        end
      end

      S_UP_CHK: begin
        if (w_key_s) begin
          // Short open-contact glitch while held: the level never dropped.
          w_state_nxt = S_DOWN;
          w_dcnt_nxt  = DCNT_ZERO;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt    = S_UP;
          w_dcnt_nxt     = DCNT_ZERO;
          w_level_nxt    = 1'b0;
          w_released_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_UP;
        w_dcnt_nxt  = DCNT_ZERO;
      end
    endcase

    // The long-press timer follows the registered debounced level.
    // - A glitch in S_UP_CHK keeps the level high, so the timer keeps running.
    // - Saturating at LONG_CYCLES gives exactly one pulse per hold.
    // - The timer only counts after the level has been high for one cycle, so
    //   the long-press pulse can never coincide with the press pulse.
    if (!r_level) begin
      w_lcnt_nxt = LCNT_ZERO;
    end else if (r_lcnt != LCNT_MAX) begin
      w_lcnt_nxt = r_lcnt + LCNT_ONE;
      if (r_lcnt == LCNT_PRE) begin
        w_long_nxt = 1'b1;
      end
    end
  end

  // State, counters and output flops. Reset clears all of them at once, so no
  // pulse can leak out when reset is applied mid-operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_UP;
      r_dcnt     <= DCNT_ZERO;
      r_lcnt     <= LCNT_ZERO;
      r_level    <= 1'b0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_lcnt     <= w_lcnt_nxt;
      r_level    <= w_level_nxt;
      r_pressed  <= w_pressed_nxt;
      r_released <= w_released_nxt;
      r_long     <= w_long_nxt;
    end
  end

  assign o_pressed    = r_pressed;
  assign o_released   = r_released;
  assign o_level      = r_level;
  assign o_long_press = r_long;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce.
// It uses small parameters (2 sync stages, 4 debounce cycles, 16 long cycles).
// The reference model is written in terms of run lengths:
// - A change is accepted once the synchronized key has disagreed with the
//   current level for DEBOUNCE_CYCLES+1 consecutive samples.
// - The long-press pulse fires when the level has already been high for
//   LONG_CYCLES edges.
// Directed steps add fixed latency expectations on top of the model.
module tb_key_debounce;
  import key_debounce_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic key_n = 1'b1;
  logic pressed, released, level, longp;

  int nCompared = 0;
  int nFailed   = 0;
  int nPressed  = 0;
  int nReleased = 0;
  int nLong     = 0;

  // Reference model state.
  logic [SYNC-1:0] mRaw   = '1;
  int   mRun    = 0;
  logic mLevel  = 1'b0;
  int   mHeld   = 0;
  logic expPressed  = 1'b0;
  logic expReleased = 1'b0;
  logic expLevel    = 1'b0;
  logic expLong     = 1'b0;

  key_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_key_n      (key_n),
    .o_pressed    (pressed),
    .o_released   (released),
    .o_level      (level),
    .o_long_press (longp)
  );

  always #5 clk = ~clk;

  // Behavioural model. On each edge it does the following:
  // 1. The FSM sees the raw key as it was SYNC edges earlier, inverted.
  // 2. Samples that disagree with the level extend a run; an agreeing sample
  //    ends it.
  // 3. A run of DEB+1 samples flips the level.
  // 4. The hold timer counts edges while the previous level was high.
  always @(posedge clk or negedge rst_n) begin : refModel
    logic seen;
    logic lvl;
    logic p;
    logic r;
    logic l;
    int   run;
    int   held;
    if (!rst_n) begin
      mRaw        <= '1;
      mRun        <= 0;
      mLevel      <= 1'b0;
      mHeld       <= 0;
      expPressed  <= 1'b0;
      expReleased <= 1'b0;
      expLevel    <= 1'b0;
      expLong     <= 1'b0;
    end else begin
      seen = ~mRaw[SYNC-1];
      lvl  = mLevel;
      run  = mRun;
      p    = 1'b0;
      r    = 1'b0;
      l    = 1'b0;
      if (seen != lvl) begin
        run = run + 1;
        if (run == DEB + 1) begin
          lvl = ~lvl;
          run = 0;
          p   = lvl;
          r   = ~lvl;
        end
      end else begin
        run = 0;
      end
      held = mHeld;
      if (!mLevel) begin
        held = 0;
      end else if (held < LONG) begin
        held = held + 1;
        l    = (held == LONG);
      end
      mRaw        <= {mRaw[SYNC-2:0], key_n};
      mRun        <= run;
      mLevel      <= lvl;
      mHeld       <= held;
      expPressed  <= p;
      expReleased <= r;
      expLevel    <= lvl;
      expLong     <= l;
    end
  end

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare all four outputs with the model, and tally the observed pulses.
  task automatic checkOutput();
    checkBit("model_pressed",  pressed,  expPressed);
    checkBit("model_released", released, expReleased);
    checkBit("model_level",    level,    expLevel);
    checkBit("model_long",     longp,    expLong);
    if (pressed)  nPressed++;
    if (released) nReleased++;
    if (longp)    nLong++;
  endtask

  // Drive the key for n clock edges, checking just after each edge.
  task automatic applyStimulus(input logic key, input int n);
    repeat (n) begin
      key_n = key;
      @(posedge clk);
      #1;
      checkOutput();
    end
  endtask

  // Hold the key until the selected pulse is seen (0 = press, 1 = release,
  // 2 = long press). Returns the number of edges taken, or -1 if the pulse
  // does not appear within maxEdges.
  task automatic holdUntilPulse(input logic key, input int which, input int maxEdges,
                                output int edges);
    logic hit;
    hit   = 1'b0;
    edges = 0;
    while (!hit && edges < maxEdges) begin
      applyStimulus(key, 1);
      edges++;
      case (which)
        0:       hit = pressed;
        1:       hit = released;
        default: hit = longp;
      endcase
    end
    if (!hit) edges = -1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin : stimulus
    int e;
    int p0;
    int r0;
    int l0;

    // 1: asynchronous reset. Outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    key_n = 1'b0;
    #1 key_n = 1'b1;
    checkBit("rst_async_pressed",  pressed,  1'b0);
    checkBit("rst_async_released", released, 1'b0);
    checkBit("rst_async_level",    level,    1'b0);
    checkBit("rst_async_long",     longp,    1'b0);
    checkBit("rst_state_up", dut.r_state === S_UP, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 1);
    checkBit("rst_toggle_level", level, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 5);

    // 2: clean press.
    $display("[TB] clean press");
    p0 = nPressed;
    r0 = nReleased;
    holdUntilPulse(1'b0, 0, 20, e);
    checkInt("press_latency", e, SYNC + DEB + 1);
    checkBit("press_level", level, 1'b1);
    applyStimulus(1'b0, 30 - 7);
    checkInt("press_count", nPressed - p0, 1);
    checkInt("press_no_release", nReleased - r0, 0);
    holdUntilPulse(1'b1, 1, 20, e);
    checkInt("release_latency_clean", e, 7);
    applyStimulus(1'b1, 5);

    // 3: bounce, followed by a steady hold.
    $display("[TB] bounce");
    p0 = nPressed;
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    checkInt("bounce_quiet", nPressed - p0, 0);
    holdUntilPulse(1'b0, 0, 20, e);
    checkInt("bounce_latency", e, 7);
    checkInt("bounce_count", nPressed - p0, 1);

    // 4: open-contact glitch while held, then a real release.
    $display("[TB] glitch and release");
    applyStimulus(1'b0, 5);
    r0 = nReleased;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 8);
    checkInt("glitch_no_release", nReleased - r0, 0);
    checkBit("glitch_level", level, 1'b1);
    holdUntilPulse(1'b1, 1, 20, e);
    checkInt("release_latency", e, 7);
    checkBit("release_level", level, 1'b0);
    applyStimulus(1'b1, 5);

    // 5: long press, then a re-press that fires it again.
    $display("[TB] long press");
    l0 = nLong;
    holdUntilPulse(1'b0, 0, 20, e);
    checkInt("long_press_latency", e, 7);
    holdUntilPulse(1'b0, 2, 40, e);
    checkInt("long_delay", e, LONG);
    applyStimulus(1'b0, 40 - 7 - LONG);
    checkInt("long_once", nLong - l0, 1);
    holdUntilPulse(1'b1, 1, 20, e);
    checkInt("long_release_latency", e, 7);
    applyStimulus(1'b1, 5);
    l0 = nLong;
    applyStimulus(1'b0, 40);
    checkInt("long_refire", nLong - l0, 1);
    applyStimulus(1'b1, 10);

    // Random run lengths, checked against the model on every edge.
    $display("[TB] random runs");
    repeat (60) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end

    // 6: reset while in S_DN_CHK, and again while in S_DOWN.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 4);
    checkBit("pre_rst_dnchk", dut.r_state === S_DN_CHK, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("rst_dnchk_level", level, 1'b0);
    checkBit("rst_dnchk_state", dut.r_state === S_UP, 1'b1);
    applyStimulus(1'b0, 2);
    rst_n = 1'b1;
    holdUntilPulse(1'b0, 0, 20, e);
    checkInt("rst_dnchk_repress", e, 7);
    applyStimulus(1'b0, 2);
    rst_n = 1'b0;
    #1;
    checkBit("rst_down_level",   level,    1'b0);
    checkBit("rst_down_pressed", pressed,  1'b0);
    checkBit("rst_down_long",    longp,    1'b0);
    applyStimulus(1'b0, 3);
    rst_n = 1'b1;
    holdUntilPulse(1'b0, 0, 20, e);
    checkInt("rst_down_repress", e, 7);
    applyStimulus(1'b1, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
